// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and the saturating ramp-step helper for the PWM ramp controller.
package pwm_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  localparam int DUTY_W_DEF = 8;
  localparam int HOLD_W_DEF = 8;

  // Operands are zero-extended to 32 bits so one helper serves any DUTY_W.
  // The result moves duty toward target by step and lands exactly on target.
  function automatic logic [31:0] sat_step(input logic [31:0] duty,
                                           input logic [31:0] target,
                                           input logic [31:0] step);
    logic [31:0] res;
    res = duty;
    if (target > duty) begin
      res = ((target - duty) <= step) ? target : duty + step;
    end else if (duty > target) begin
      res = ((duty - target) <= step) ? target : duty - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_hold_counter.sv
// Counts PWM periods between ramp steps: loadable, decrements on wrap, flags zero.
module pwm_hold_counter #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [HOLD_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the PWM datapath: accepts a target duty, steps duty_out toward it
// on period boundaries, and drives the PWM enable plus busy/done status.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DUTY_W-1:0] cfg_target,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              abort,
  input  logic              period_wrap,
  output logic [DUTY_W-1:0] duty_out,
  output logic              pwm_en,
  output logic              busy,
  output logic              done
);

  state_e            r_state;
  state_e            w_next_state;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] r_step;
  logic [HOLD_W-1:0] r_hold;
  logic              r_done;

  logic              w_accept;
  logic              w_duty_upd;
  logic              w_done_nxt;
  logic              w_hold_load;
  logic              w_hold_dec;
  logic              w_hold_zero;
  logic [HOLD_W-1:0] w_hold_val;
  logic [DUTY_W-1:0] w_step_duty;

  assign w_step_duty = DUTY_W'(sat_step(32'(r_duty), 32'(r_target), 32'(r_step)));

  // Handshake: a request transfers on a cycle where cfg_valid && cfg_ready && !abort.
  // cfg_ready depends only on state; an abort in the same cycle drops the request.
  assign cfg_ready = (r_state == ST_IDLE);
  assign w_accept  = cfg_valid && cfg_ready && !abort;

  always_comb begin
    w_next_state = r_state;
    w_duty_upd   = 1'b0;
    w_done_nxt   = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_dec   = 1'b0;
    w_hold_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_hold_load = 1'b1;
          if (cfg_target == r_duty) begin
            w_done_nxt = 1'b1;
          end else begin
            w_next_state = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (period_wrap) begin
          if (!w_hold_zero) begin
            w_hold_dec = 1'b1;
          end else begin
            w_duty_upd  = 1'b1;
            w_hold_load = 1'b1;
            w_hold_val  = r_hold;
            if (w_step_duty == r_target) begin
              w_next_state = ST_IDLE;
              w_done_nxt   = 1'b1;
            end
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_hold   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_target <= cfg_target;
        r_step   <= (cfg_step == '0) ? DUTY_W'(1) : cfg_step;
        r_hold   <= cfg_hold;
      end
      if (w_duty_upd) begin
        r_duty <= w_step_duty;
      end
    end
  end

  pwm_hold_counter #(
    .HOLD_W(HOLD_W)
  ) u_hold_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_hold_load),
    .i_load_val(w_hold_val),
    .i_dec     (w_hold_dec),
    .o_zero    (w_hold_zero)
  );

  // Idle at 0% duty stops the PWM counter entirely.
  assign pwm_en   = (r_state == ST_RAMP) || (r_duty != '0);
  assign busy     = (r_state == ST_RAMP);
  assign duty_out = r_duty;
  assign done     = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps, saturation, hold, abort and async reset.
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_target;
  logic [7:0] cfg_step;
  logic [7:0] cfg_hold;
  logic       abort;
  logic       period_wrap;
  logic [7:0] duty_out;
  logic       pwm_en;
  logic       busy;
  logic       done;

  int         n_checks;
  int         n_errors;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] prev_v;

  localparam int WRAP_GAP = 256;

  pwm_ramp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_target (cfg_target),
    .cfg_step   (cfg_step),
    .cfg_hold   (cfg_hold),
    .abort      (abort),
    .period_wrap(period_wrap),
    .duty_out   (duty_out),
    .pwm_en     (pwm_en),
    .busy       (busy),
    .done       (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [7:0] t, input logic [7:0] s, input logic [7:0] h);
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_step   = s;
    cfg_hold   = h;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wrap_pulse();
    repeat (WRAP_GAP - 1) tick();
    period_wrap = 1'b1;
    tick();
    period_wrap = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_target  = '0;
    cfg_step    = '0;
    cfg_hold    = '0;
    abort       = 1'b0;
    period_wrap = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();

    // 1. reset state
    check("rst_duty", duty_out, 8'h00);
    check("rst_pwm_en", pwm_en, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // 2. up-ramp 0 -> 0x40, step 0x10, hold 0
    send_cfg(8'h40, 8'h10, 8'h00);
    check("up_busy", busy, 1'b1);
    check("up_ready", cfg_ready, 1'b0);
    check("up_pwm_en", pwm_en, 1'b1);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    while (exp_q.size() > 0) begin
      wrap_pulse();
      exp_v = exp_q.pop_front();
      check("up_duty", duty_out, exp_v);
      check("up_done", done, (exp_q.size() == 0));
    end
    check("up_end_busy", busy, 1'b0);
    tick();
    check("up_done_pulse", done, 1'b0);

    // 3. down-ramp 0x40 -> 0x05, step 0x10, hold 1
    send_cfg(8'h05, 8'h10, 8'h01);
    exp_q  = '{8'h30, 8'h20, 8'h10, 8'h05};
    prev_v = 8'h40;
    while (exp_q.size() > 0) begin
      if (prev_v != 8'h40) begin
        wrap_pulse();
        check("dn_hold", duty_out, prev_v);
      end
      wrap_pulse();
      exp_v = exp_q.pop_front();
      check("dn_duty", duty_out, exp_v);
      check("dn_done", done, (exp_q.size() == 0));
      prev_v = exp_v;
    end
    check("dn_end_busy", busy, 1'b0);
    wrap_pulse();
    check("dn_floor", duty_out, 8'h05);

    // 4a. 0x05 -> 0xFE in one saturating step, then step 0 treated as 1
    send_cfg(8'hFE, 8'hF9, 8'h00);
    wrap_pulse();
    check("fe_duty", duty_out, 8'hFE);
    send_cfg(8'hFF, 8'h00, 8'h00);
    check("ff_busy", busy, 1'b1);
    wrap_pulse();
    check("ff_duty", duty_out, 8'hFF);
    check("ff_done", done, 1'b1);
    check("ff_idle", busy, 1'b0);
    wrap_pulse();
    check("idle_wrap_ignored", duty_out, 8'hFF);

    // 4b. target equals current duty
    send_cfg(8'hFF, 8'h05, 8'h00);
    check("eq_done", done, 1'b1);
    check("eq_busy", busy, 1'b0);
    tick();
    check("eq_done_pulse", done, 1'b0);

    // 5. abort coincident with wrap at 0x20
    send_cfg(8'h00, 8'hDF, 8'h00);
    wrap_pulse();
    check("ab_pre_duty", duty_out, 8'h20);
    check("ab_pre_busy", busy, 1'b1);
    repeat (WRAP_GAP - 1) tick();
    abort       = 1'b1;
    period_wrap = 1'b1;
    tick();
    abort       = 1'b0;
    period_wrap = 1'b0;
    check("ab_duty", duty_out, 8'h20);
    check("ab_done", done, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_ready", cfg_ready, 1'b1);
    check("ab_pwm_en", pwm_en, 1'b1);
    abort      = 1'b1;
    cfg_valid  = 1'b1;
    cfg_target = 8'h80;
    cfg_step   = 8'h10;
    #1;
    check("ab_cfg_ready", cfg_ready, 1'b1);
    tick();
    abort     = 1'b0;
    cfg_valid = 1'b0;
    check("ab_drop_busy", busy, 1'b0);
    check("ab_drop_done", done, 1'b0);
    wrap_pulse();
    check("ab_drop_duty", duty_out, 8'h20);
    send_cfg(8'h30, 8'h10, 8'h00);
    check("ab_new_busy", busy, 1'b1);
    wrap_pulse();
    check("ab_new_duty", duty_out, 8'h30);
    check("ab_new_done", done, 1'b1);

    // 6. request ignored in RAMP, then async reset mid-ramp
    send_cfg(8'h00, 8'h10, 8'h00);
    cfg_valid  = 1'b1;
    cfg_target = 8'h80;
    cfg_step   = 8'hFF;
    #1;
    check("rmp_ready", cfg_ready, 1'b0);
    tick();
    cfg_valid = 1'b0;
    wrap_pulse();
    check("rmp_ign_duty", duty_out, 8'h20);
    check("rmp_ign_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_duty", duty_out, 8'h00);
    check("arst_pwm_en", pwm_en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", cfg_ready, 1'b1);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("arst_done", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
